alu_decode: RTL and testbench
=============================

// Module: alu_decode
// PURPOSE
//  Producer side of the ALU control interface, in the ID stage. Decodes RV32I instructions
//  (plus optional RV32M multiply) into ALU select, operand selects and the immediate.
//  Registered output behind a valid/ready handshake with a 2-entry skid buffer.
//  Feeds the EX-stage ALU.
// PARAMETERS
//  XLEN   32  datapath width (inst, pc, imm)
// PORTS
//  clk          in   1     system clock
//  rst          in   1     synchronous, active-high reset
//  in_valid     in   1     fetch presents in_inst/in_pc
//  in_ready     out  1     decode can accept this cycle
//  in_inst      in   XLEN  instruction word
//  in_pc        in   XLEN  PC of in_inst
//  flush        in   1     kill all held and incoming entries (branch redirect)
//  out_valid    out  1     decoded entry available
//  out_ready    in   1     EX consumes the entry
//  out_alu_sel  out  4     ALU op: 0000 add, 0001 sll, 0010 slt, 0011 sltu, 0100 xor, 0101 srl,
//                          0110 or, 0111 and, 1100 sub, 1101 sra, 1111 pass-B, 1000-1011 mul*
//  out_a_sel    out  1     0 = rs1, 1 = PC
//  out_b_sel    out  1     0 = rs2, 1 = imm
//  out_imm      out  XLEN  sign-extended immediate
//  out_pc       out  XLEN  PC of the decoded entry
//  out_illegal  out  1     unsupported encoding; alu_sel forced to 0000
// BEHAVIOUR
//  - Reset: out_valid=0; all out_* data = 0; in_ready=0 while rst is high, 1 on first cycle after.
//  - Transfer occurs when valid&&ready on the same edge. Latency: accepted in cycle N -> out_valid in N+1.
//  - Skid buffer: main reg + skid reg. in_ready = !skid_full (registered, no comb path from out_ready).
//    Accept while main is held (out_valid&&!out_ready) -> goes to skid. Order is strict FIFO.
//  - Full-throughput: with out_ready=1 continuously, one entry per cycle, no bubbles.
//  - flush: next cycle out_valid=0, skid empty, in_ready=1. Flush dominates a same-cycle accept.
//    Flush and out_ready in the same cycle: the current output counts as consumed.
//  - OP (0110011): funct3 -> add/sll/slt/sltu/xor/srl/or/and. funct7=0100000 with f3=000 -> sub.
//    funct7=0100000 with f3=101 -> sra. Any other funct7 -> illegal (see MEXT). a_sel=0, b_sel=0.
//  - OP-IMM (0010011): same map, never sub. b_sel=1.
//    slli/srli/srai imm = {27'b0,shamt}. srai needs imm[11:5]=0100000, slli/srli need 0; else illegal.
//  - LOAD/STORE/JALR: add, b_sel=1, a_sel=0 (I or S imm).
//  - JAL/BRANCH/AUIPC: add, a_sel=1, b_sel=1 (J, B or U imm).
//  - LUI: pass-B (1111), b_sel=1, U imm.
//  - Any other opcode -> illegal=1, alu_sel=0000, selects 0, imm 0.
//  - Imm: I {{20{i[31]}},i[31:20]}; S {{20{i[31]}},i[31:25],i[11:7]};
//    B {{19{i[31]}},i[31],i[7],i[30:25],i[11:8],1'b0}; U {i[31:12],12'b0};
//    J {{11{i[31]}},i[31],i[19:12],i[20],i[30:21],1'b0}.
// CONFIGURATION
//  ALU_DECODE_MEXT_EN defined: OP with funct7=0000001 and f3 000/001/010/011 -> mul 1000,
//    mulh 1001, mulhsu 1010, mulhu 1011. f3 100-111 (div/rem) -> illegal.
//  Undefined: every funct7=0000001 encoding -> illegal.
// STRUCTURE
//  Shared package alu_pkg: ALU_* 4-bit select constants, OPC_* 7-bit opcode constants,
//    F7_* funct7 constants. The ALU uses the same package.
//  One sub-module imm_gen (comb: inst -> imm by format). Decode logic and skid buffer stay in this module.
// TESTING
//  1 rst 3 cycles, then in 0x002081B3 (add) -> next cycle out_valid=1, alu_sel=0000, a_sel=0, b_sel=0, illegal=0.
//  2 in 0x402081B3 -> alu_sel=1100. in 0x40335293 (srai x5,x6,3) -> alu_sel=1101, b_sel=1, imm=0x00000003.
//  3 in 0x123450B7 (lui) -> alu_sel=1111, imm=0x12345000. in 0xFFDFF0EF (jal -4) -> alu_sel=0000, a_sel=1, imm=0xFFFFFFFC.
//  4 out_ready=0, stream 3 instrs -> 2 accepted, in_ready=0. Raise out_ready -> drained in order, no loss/duplication.
//  5 Skid full, then flush and in_valid together -> next cycle out_valid=0, in_ready=1, the flushed-cycle input is dropped.
//  6 in 0x022081B3 (mul): MEXT_EN -> alu_sel=1000, illegal=0. Without it -> illegal=1, alu_sel=0000.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU control definitions: select codes, opcodes, funct7 values,
// immediate formats and the decoded-entry payload. Also used by the EX ALU.
package alu_pkg;

    localparam int unsigned XLEN = 32;

    // ALU select codes
    localparam logic [3:0] ALU_ADD    = 4'b0000;
    localparam logic [3:0] ALU_SLL    = 4'b0001;
    localparam logic [3:0] ALU_SLT    = 4'b0010;
    localparam logic [3:0] ALU_SLTU   = 4'b0011;
    localparam logic [3:0] ALU_XOR    = 4'b0100;
    localparam logic [3:0] ALU_SRL    = 4'b0101;
    localparam logic [3:0] ALU_OR     = 4'b0110;
    localparam logic [3:0] ALU_AND    = 4'b0111;
    localparam logic [3:0] ALU_MUL    = 4'b1000;
    localparam logic [3:0] ALU_MULH   = 4'b1001;
    localparam logic [3:0] ALU_MULHSU = 4'b1010;
    localparam logic [3:0] ALU_MULHU  = 4'b1011;
    localparam logic [3:0] ALU_SUB    = 4'b1100;
    localparam logic [3:0] ALU_SRA    = 4'b1101;
    localparam logic [3:0] ALU_PASSB  = 4'b1111;

    // RV32I major opcodes
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    // funct7 values
    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MEXT = 7'b0000001;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_SHAMT
    } imm_fmt_e;

    typedef struct packed {
        logic [3:0]      alu_sel;
        logic            a_sel;
        logic            b_sel;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic            illegal;
    } dec_entry_t;

    // funct3 -> base integer ALU op (no sub/sra distinction)
    function automatic logic [3:0] alu_base_sel(input logic [2:0] f3);
        logic [3:0] sel;
        case (f3)
            3'd0:    sel = ALU_ADD;
            3'd1:    sel = ALU_SLL;
            3'd2:    sel = ALU_SLT;
            3'd3:    sel = ALU_SLTU;
            3'd4:    sel = ALU_XOR;
            3'd5:    sel = ALU_SRL;
            3'd6:    sel = ALU_OR;
            default: sel = ALU_AND;
        endcase
        return sel;
    endfunction

    // funct3[1:0] -> multiply variant
    function automatic logic [3:0] alu_mul_sel(input logic [1:0] f3_lo);
        logic [3:0] sel;
        case (f3_lo)
            2'd0:    sel = ALU_MUL;
            2'd1:    sel = ALU_MULH;
            2'd2:    sel = ALU_MULHSU;
            default: sel = ALU_MULHU;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/alu_decode_if.sv
// Decode-stage bus: fetch-side request (in_*), flush, and EX-side decoded entry (out_*).
// master = decoder (drives in_ready and out_*), slave = surrounding pipeline.
interface alu_decode_if;
    logic                       in_valid;
    logic                       in_ready;
    logic [alu_pkg::XLEN-1:0]   in_inst;
    logic [alu_pkg::XLEN-1:0]   in_pc;
    logic                       flush;
    logic                       out_valid;
    logic                       out_ready;
    logic [3:0]                 out_alu_sel;
    logic                       out_a_sel;
    logic                       out_b_sel;
    logic [alu_pkg::XLEN-1:0]   out_imm;
    logic [alu_pkg::XLEN-1:0]   out_pc;
    logic                       out_illegal;

    modport master (
        input  in_valid, in_inst, in_pc, flush, out_ready,
        output in_ready, out_valid, out_alu_sel, out_a_sel, out_b_sel,
               out_imm, out_pc, out_illegal
    );

    modport slave (
        output in_valid, in_inst, in_pc, flush, out_ready,
        input  in_ready, out_valid, out_alu_sel, out_a_sel, out_b_sel,
               out_imm, out_pc, out_illegal
    );
endinterface

// File: rtl/imm_gen.sv
// Immediate generator (combinational): instruction bits [31:7] + format -> sign-extended imm.
// Ports: inst_i (instruction bits 31..7), fmt_i (format select), imm_c_o (immediate).
module imm_gen
    import alu_pkg::*;
(
    input  logic [XLEN-1:7] inst_i,
    input  imm_fmt_e        fmt_i,
    output logic [XLEN-1:0] imm_c_o
);

    always_comb begin
        imm_c_o = '0;
        case (fmt_i)
            IMM_I:     imm_c_o = {{20{inst_i[31]}}, inst_i[31:20]};
            IMM_S:     imm_c_o = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
            IMM_B:     imm_c_o = {{19{inst_i[31]}}, inst_i[31], inst_i[7],
                                  inst_i[30:25], inst_i[11:8], 1'b0};
            IMM_U:     imm_c_o = {inst_i[31:12], 12'b0};
            IMM_J:     imm_c_o = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12],
                                  inst_i[20], inst_i[30:21], 1'b0};
            IMM_SHAMT: imm_c_o = {27'b0, inst_i[24:20]};
            default:   imm_c_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_decode.sv
// ID-stage decoder: RV32I (+ optional RV32M multiply when ALU_DECODE_MEXT_EN is defined)
// into ALU select, operand selects and immediate, registered behind a 2-entry skid buffer.
// Ports: clk, rst (sync, active-high), bus (alu_decode_if.master: in_* request,
//        flush, out_* decoded entry with valid/ready).
module alu_decode
    import alu_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    alu_decode_if.master bus
);

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    imm_fmt_e    fmt;
    logic [XLEN-1:0] imm_c;
    dec_entry_t  dec_c;

    dec_entry_t  main_q, main_d;
    dec_entry_t  skid_q, skid_d;
    logic        main_valid_q, main_valid_d;
    logic        skid_valid_q, skid_valid_d;
    logic        in_ready_q, in_ready_d;
    logic        accept, pop;

    assign opcode = bus.in_inst[6:0];
    assign f3     = bus.in_inst[14:12];
    assign f7     = bus.in_inst[31:25];

    imm_gen u_imm_gen (
        .inst_i  (bus.in_inst[XLEN-1:7]),
        .fmt_i   (fmt),
        .imm_c_o (imm_c)
    );

    // Instruction decode
    always_comb begin
        dec_c         = '0;
        dec_c.alu_sel = ALU_ADD;
        dec_c.pc      = bus.in_pc;
        fmt           = IMM_NONE;
        case (opcode)
            OPC_OP: begin
                case (f7)
                    F7_ZERO: dec_c.alu_sel = alu_base_sel(f3);
                    F7_ALT: begin
                        if (f3 == 3'd0)      dec_c.alu_sel = ALU_SUB;
                        else if (f3 == 3'd5) dec_c.alu_sel = ALU_SRA;
                        else                 dec_c.illegal = 1'b1;
                    end
                    F7_MEXT: begin
`ifdef ALU_DECODE_MEXT_EN
                        // div/rem (funct3[2]=1) are not supported
                        if (!f3[2]) dec_c.alu_sel = alu_mul_sel(f3[1:0]);
                        else        dec_c.illegal = 1'b1;
`else
                        dec_c.illegal = 1'b1;
`endif
                    end
                    default: dec_c.illegal = 1'b1;
                endcase
            end
            OPC_OP_IMM: begin
                dec_c.b_sel = 1'b1;
                if (f3 == 3'd1) begin
                    fmt           = IMM_SHAMT;
                    dec_c.alu_sel = ALU_SLL;
                    dec_c.illegal = (f7 != F7_ZERO);
                end else if (f3 == 3'd5) begin
                    fmt = IMM_SHAMT;
                    if (f7 == F7_ZERO)     dec_c.alu_sel = ALU_SRL;
                    else if (f7 == F7_ALT) dec_c.alu_sel = ALU_SRA;
                    else                   dec_c.illegal = 1'b1;
                end else begin
                    fmt           = IMM_I;
                    dec_c.alu_sel = alu_base_sel(f3);
                end
            end
            OPC_LOAD, OPC_JALR: begin
                fmt         = IMM_I;
                dec_c.b_sel = 1'b1;
            end
            OPC_STORE: begin
                fmt         = IMM_S;
                dec_c.b_sel = 1'b1;
            end
            OPC_JAL: begin
                fmt         = IMM_J;
                dec_c.a_sel = 1'b1;
                dec_c.b_sel = 1'b1;
            end
            OPC_BRANCH: begin
                fmt         = IMM_B;
                dec_c.a_sel = 1'b1;
                dec_c.b_sel = 1'b1;
            end
            OPC_AUIPC: begin
                fmt         = IMM_U;
                dec_c.a_sel = 1'b1;
                dec_c.b_sel = 1'b1;
            end
            OPC_LUI: begin
                fmt           = IMM_U;
                dec_c.alu_sel = ALU_PASSB;
                dec_c.b_sel   = 1'b1;
            end
            default: dec_c.illegal = 1'b1;
        endcase
        // Illegal encodings carry only the PC and the illegal flag
        if (dec_c.illegal) begin
            dec_c.alu_sel = ALU_ADD;
            dec_c.a_sel   = 1'b0;
            dec_c.b_sel   = 1'b0;
            fmt           = IMM_NONE;
        end
        dec_c.imm = imm_c;
    end

    assign accept = bus.in_valid && in_ready_q;
    assign pop    = main_valid_q && bus.out_ready;

    // Skid buffer next state: skid always drains into main before new input
    always_comb begin
        main_d       = main_q;
        main_valid_d = main_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (bus.flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || pop) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = accept;
                if (accept) skid_d = dec_c;
            end else begin
                main_valid_d = accept;
                if (accept) main_d = dec_c;
            end
        end else if (accept) begin
            skid_d       = dec_c;
            skid_valid_d = 1'b1;
        end
        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = main_valid_q;
    assign bus.out_alu_sel = main_q.alu_sel;
    assign bus.out_a_sel   = main_q.a_sel;
    assign bus.out_b_sel   = main_q.b_sel;
    assign bus.out_imm     = main_q.imm;
    assign bus.out_pc      = main_q.pc;
    assign bus.out_illegal = main_q.illegal;

endmodule

// File: tb/tb_alu_decode.sv
// Self-checking bench for alu_decode: directed steps, scoreboard of reference decodes.
module tb_alu_decode;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_decode_if bus ();

    alu_decode dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef ALU_DECODE_MEXT_EN
    localparam bit MEXT = 1'b1;
`else
    localparam bit MEXT = 1'b0;
`endif

    int tests = 0;
    int fails = 0;
    int pops  = 0;
    logic [31:0] pc_ctr = 32'h0000_1000;
    logic [70:0] sb[$];

    task automatic chk(input string tag, input logic [70:0] obs, input logic [70:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference decode: {alu_sel, a_sel, b_sel, imm, pc, illegal}
    function automatic logic [70:0] ref_dec(input logic [31:0] i, input logic [31:0] pc);
        logic [3:0]  alu;
        logic        a, b, ill;
        logic [31:0] imm;
        logic [2:0]  f3;
        logic [6:0]  f7;
        f3 = i[14:12];
        f7 = i[31:25];
        alu = 4'h0; a = 1'b0; b = 1'b0; ill = 1'b0; imm = 32'h0;
        case (i[6:0])
            7'h33: begin
                if (f7 == 7'h00)                      alu = {1'b0, f3};
                else if (f7 == 7'h20 && f3 == 3'd0)   alu = 4'hC;
                else if (f7 == 7'h20 && f3 == 3'd5)   alu = 4'hD;
                else if (f7 == 7'h01 && MEXT && f3 < 3'd4) alu = 4'h8 + {2'b00, f3[1:0]};
                else                                  ill = 1'b1;
            end
            7'h13: begin
                b = 1'b1;
                if (f3 == 3'd1 || f3 == 3'd5) begin
                    imm = {27'h0, i[24:20]};
                    if (f7 == 7'h00)                    alu = {1'b0, f3};
                    else if (f7 == 7'h20 && f3 == 3'd5) alu = 4'hD;
                    else                                ill = 1'b1;
                end else begin
                    alu = {1'b0, f3};
                    imm = {{20{i[31]}}, i[31:20]};
                end
            end
            7'h03, 7'h67: begin b = 1'b1; imm = {{20{i[31]}}, i[31:20]}; end
            7'h23: begin b = 1'b1; imm = {{20{i[31]}}, i[31:25], i[11:7]}; end
            7'h6F: begin a = 1'b1; b = 1'b1;
                         imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0}; end
            7'h63: begin a = 1'b1; b = 1'b1;
                         imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0}; end
            7'h17: begin a = 1'b1; b = 1'b1; imm = {i[31:12], 12'h0}; end
            7'h37: begin alu = 4'hF; b = 1'b1; imm = {i[31:12], 12'h0}; end
            default: ill = 1'b1;
        endcase
        if (ill) begin alu = 4'h0; a = 1'b0; b = 1'b0; imm = 32'h0; end
        return {alu, a, b, imm, pc, ill};
    endfunction

    function automatic logic [70:0] observed();
        return {bus.out_alu_sel, bus.out_a_sel, bus.out_b_sel, bus.out_imm,
                bus.out_pc, bus.out_illegal};
    endfunction

    // One clock: scoreboard pop/push at negedge, return 1 time unit after posedge
    task automatic tick();
        logic [70:0] exp;
        @(negedge clk);
        if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                chk("spurious_out", 71'(bus.out_valid), 71'(0));
            end else begin
                exp = sb.pop_front();
                chk("sb_pop", observed(), exp);
                pops++;
            end
        end
        if (!rst) begin
            if (bus.flush) sb.delete();
            else if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1)
                sb.push_back(ref_dec(bus.in_inst, bus.in_pc));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] inst);
        bus.in_valid = 1'b1;
        bus.in_inst  = inst;
        bus.in_pc    = pc_ctr;
        pc_ctr       = pc_ctr + 32'd4;
        tick();
    endtask

    logic [31:0] mix [16] = '{
        32'h00A30313, 32'hFFF34293, 32'h0062F2B3, 32'h00112623,
        32'hFFC12083, 32'hFE000EE3, 32'h00001517, 32'h000080E7,
        32'h00209093, 32'h40209093, 32'h0000007F, 32'h202081B3,
        32'h0220C1B3, 32'h0020D1B3, 32'h4020D1B3, 32'h0010B093
    };

    initial begin
        int bubbles;
        int pops0;
        int budget;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_inst   = '0;
        bus.in_pc     = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state
        repeat (3) tick();
        chk("rst_out_valid", 71'(bus.out_valid), 71'(0));
        chk("rst_in_ready",  71'(bus.in_ready),  71'(0));
        chk("rst_data",      observed(),         71'(0));
        rst = 1'b0;
        tick();
        chk("post_rst_in_ready",  71'(bus.in_ready),  71'(1));
        chk("post_rst_out_valid", 71'(bus.out_valid), 71'(0));

        bus.out_ready = 1'b1;
        // add: one-cycle latency
        drive(32'h002081B3);
        chk("add_valid", 71'(bus.out_valid), 71'(1));
        chk("add_fields", 71'({bus.out_alu_sel, bus.out_a_sel, bus.out_b_sel, bus.out_illegal}),
            71'({4'b0000, 1'b0, 1'b0, 1'b0}));
        drive(32'h402081B3);
        chk("sub_sel", 71'(bus.out_alu_sel), 71'(4'b1100));
        drive(32'h40335293);
        chk("srai", 71'({bus.out_alu_sel, bus.out_b_sel, bus.out_imm}),
            71'({4'b1101, 1'b1, 32'h00000003}));
        drive(32'h123450B7);
        chk("lui", 71'({bus.out_alu_sel, bus.out_imm}), 71'({4'b1111, 32'h12345000}));
        drive(32'hFFDFF0EF);
        chk("jal", 71'({bus.out_alu_sel, bus.out_a_sel, bus.out_imm}),
            71'({4'b0000, 1'b1, 32'hFFFFFFFC}));
        drive(32'h022081B3);
        if (MEXT)
            chk("mul", 71'({bus.out_alu_sel, bus.out_illegal}), 71'({4'b1000, 1'b0}));
        else
            chk("mul", 71'({bus.out_alu_sel, bus.out_illegal}), 71'({4'b0000, 1'b1}));

        // Back-to-back mix with out_ready high: no bubbles expected
        bubbles = 0;
        foreach (mix[k]) begin
            drive(mix[k]);
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b1) bubbles++;
        end
        chk("throughput_bubbles", 71'(bubbles), 71'(0));
        bus.in_valid = 1'b0;
        tick();
        chk("stream_drained", 71'(sb.size()), 71'(0));

        // Backpressure: 3 offered, 2 accepted, drained in order
        bus.out_ready = 1'b0;
        drive(32'h00100093);
        drive(32'h00200113);
        drive(32'h00300193);
        bus.in_valid = 1'b0;
        chk("bp_in_ready", 71'(bus.in_ready), 71'(0));
        chk("bp_held", 71'(sb.size()), 71'(2));
        pops0 = pops;
        bus.out_ready = 1'b1;
        budget = 10;
        while (sb.size() != 0 && budget > 0) begin
            tick();
            budget--;
        end
        chk("bp_drain_count", 71'(pops - pops0), 71'(2));
        chk("bp_empty_valid", 71'(bus.out_valid), 71'(0));
        chk("bp_empty_ready", 71'(bus.in_ready), 71'(1));

        // Flush with skid full plus simultaneous input
        bus.out_ready = 1'b0;
        drive(32'h00400213);
        drive(32'h00500293);
        chk("fl_full", 71'(bus.in_ready), 71'(0));
        bus.flush    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_inst  = 32'h00600313;
        tick();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        chk("fl_out_valid", 71'(bus.out_valid), 71'(0));
        chk("fl_in_ready",  71'(bus.in_ready),  71'(1));
        bus.out_ready = 1'b1;
        repeat (3) tick();
        chk("fl_no_output", 71'(bus.out_valid), 71'(0));

        // Flush beats a same-cycle accept; the current output is consumed
        drive(32'h00700393);
        pops0 = pops;
        bus.flush   = 1'b1;
        bus.in_inst = 32'h00800413;
        bus.in_pc   = pc_ctr;
        tick();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        chk("fl2_consumed", 71'(pops - pops0), 71'(1));
        chk("fl2_out_valid", 71'(bus.out_valid), 71'(0));
        repeat (2) tick();
        chk("fl2_dropped", 71'(bus.out_valid), 71'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
